// File: rtl/relm_i2c_pkg.sv
// Shared definitions for the ReLM I2C byte engine: command/status field
// positions, op codes, FSM states and the START/STOP line-level table.
package relm_i2c_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_XFER,
        ST_END
    } state_e;

    // STAT_BUSY counts down from the valid bit: busy lives at bit WD-STAT_BUSY.
    localparam int STAT_BUSY  = 1;
    localparam int STAT_NACK  = 8;
    localparam int STAT_STALL = 9;
    localparam int CMD_OP     = 8;
    localparam int CMD_ACK    = 10;

    // Returns {scl, sda} for one quarter of a START (is_stop=0) or STOP frame.
    function automatic logic [1:0] framing_levels(input logic is_stop, input logic [1:0] q);
        logic [1:0] lv;
        lv = 2'b11;
        if (!is_stop) begin
            case (q)
                2'd0:    lv = 2'b01;
                2'd1:    lv = 2'b11;
                2'd2:    lv = 2'b10;
                default: lv = 2'b00;
            endcase
        end else begin
            case (q)
                2'd0:    lv = 2'b00;
                2'd1:    lv = 2'b10;
                default: lv = 2'b11;
            endcase
        end
        return lv;
    endfunction

endpackage

// File: rtl/relm_i2c_ctrl_if.sv
// ReLM push (command/retry) and pop (status) ports of the I2C byte engine.
interface relm_i2c_ctrl_if #(parameter int WD = 32);

    logic [WD:0] cmd_d;
    logic        cmd_retry;
    logic [WD:0] stat_q;

    modport master (output cmd_d, input cmd_retry, input stat_q);
    modport slave  (input cmd_d, output cmd_retry, output stat_q);

endinterface

// File: rtl/relm_i2c_tick.sv
// Quarter-bit divider: counts 0..DIV-1 while running and strobes on the last
// count; hold freezes the count so a stretched SCL lengthens the quarter.
module relm_i2c_tick #(
    parameter int DIV = 125
) (
    input  logic clk,
    input  logic rst_in,
    input  logic run,
    input  logic hold,
    output logic strobe
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic          last;

    assign last   = (cnt == CW'(DIV - 1));
    assign strobe = run && !hold && last;

    always_ff @(posedge clk) begin
        if (rst_in || !run) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/relm_i2c_ctrl.sv
// I2C byte engine on a ReLM push/pop port pair: START, STOP, byte WRITE with
// ACK sample, byte READ with ACK/NACK send. Clock stretching via I2C_STRETCH_EN.
module relm_i2c_ctrl #(
    parameter int WD  = 32,
    parameter int DIV = 125
) (
    input  logic           clk,
    input  logic           rst_in,
    relm_i2c_ctrl_if.slave relm,
    output logic           scl_out,
    output logic           sda_out,
`ifdef I2C_STRETCH_EN
    input  logic           scl_in,
`endif
    input  logic           sda_in
);

    import relm_i2c_pkg::*;

    state_e      state, state_nxt;
    logic [1:0]  q, q_nxt;
    logic [3:0]  bit_idx, bit_idx_nxt;
    logic        is_read, is_read_nxt;
    logic [7:0]  tx_byte, tx_nxt;
    logic        ack_lvl, ack_lvl_nxt;
    logic [7:0]  rx_shift, rx_nxt;
    logic        ack_smp, ack_smp_nxt;
    logic [7:0]  rdata, rdata_nxt;
    logic        nack, nack_nxt;
    logic        busy, busy_nxt;
    logic        scl_nxt, sda_nxt;
    logic [2:0]  bsel;
    logic [WD:0] stat_nxt;
    logic        sda_s1, sda_s2;
    logic        strobe, hold, stall, accept;
    op_e         cmd_op;
    logic        unused_cmd_bits;

    assign cmd_op          = op_e'(relm.cmd_d[CMD_OP +: 2]);
    assign accept          = relm.cmd_d[WD] && !busy;
    assign relm.cmd_retry  = busy;
    assign unused_cmd_bits = ^relm.cmd_d[WD-1:CMD_ACK+1];

`ifdef I2C_STRETCH_EN
    logic scl_s1, scl_s2;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
        end
    end

    // A released SCL that still reads low means a slave is stretching.
    assign hold = busy && scl_out && !scl_s2;
`else
    assign hold = 1'b0;
`endif
    assign stall = hold;

    relm_i2c_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_in (rst_in),
        .run    (busy),
        .hold   (hold),
        .strobe (strobe)
    );

    // Next-state logic; results are held in shadow regs and committed on entry to END.
    always_comb begin
        state_nxt   = state;
        q_nxt       = q;
        bit_idx_nxt = bit_idx;
        is_read_nxt = is_read;
        tx_nxt      = tx_byte;
        ack_lvl_nxt = ack_lvl;
        rx_nxt      = rx_shift;
        ack_smp_nxt = ack_smp;
        rdata_nxt   = rdata;
        nack_nxt    = nack;
        busy_nxt    = busy;

        case (state)
            ST_IDLE, ST_END: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    busy_nxt    = 1'b1;
                    q_nxt       = 2'd0;
                    bit_idx_nxt = 4'd8;
                    tx_nxt      = relm.cmd_d[7:0];
                    ack_lvl_nxt = relm.cmd_d[CMD_ACK];
                    is_read_nxt = (cmd_op == OP_READ);
                    case (cmd_op)
                        OP_START: state_nxt = ST_START;
                        OP_STOP:  state_nxt = ST_STOP;
                        default:  state_nxt = ST_XFER;
                    endcase
                end
            end
            ST_START, ST_STOP: begin
                if (strobe) begin
                    q_nxt = q + 2'd1;
                    if (q == 2'd3) begin
                        state_nxt = ST_END;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            ST_XFER: begin
                if (strobe) begin
                    q_nxt = q + 2'd1;
                    if (q == 2'd1) begin
                        if (is_read && bit_idx != 4'd0)
                            rx_nxt = {rx_shift[6:0], sda_s2};
                        if (!is_read && bit_idx == 4'd0)
                            ack_smp_nxt = sda_s2;
                    end
                    if (q == 2'd3) begin
                        if (bit_idx == 4'd0) begin
                            state_nxt = ST_END;
                            busy_nxt  = 1'b0;
                            if (is_read)
                                rdata_nxt = rx_shift;
                            else
                                nack_nxt = ack_smp;
                        end else begin
                            bit_idx_nxt = bit_idx - 4'd1;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Lines are decoded from the next state so the registered pins line up with q.
        scl_nxt = scl_out;
        sda_nxt = sda_out;
        bsel    = 3'(bit_idx_nxt - 4'd1);
        case (state_nxt)
            ST_START: {scl_nxt, sda_nxt} = framing_levels(1'b0, q_nxt);
            ST_STOP:  {scl_nxt, sda_nxt} = framing_levels(1'b1, q_nxt);
            ST_XFER: begin
                scl_nxt = (q_nxt == 2'd1) || (q_nxt == 2'd2);
                if (bit_idx_nxt == 4'd0)
                    sda_nxt = is_read_nxt ? ack_lvl_nxt : 1'b1;
                else
                    sda_nxt = is_read_nxt ? 1'b1 : tx_nxt[bsel];
            end
            default: begin
            end
        endcase

        stat_nxt                 = '0;
        stat_nxt[WD - STAT_BUSY] = busy_nxt;
        stat_nxt[STAT_STALL]     = stall;
        stat_nxt[STAT_NACK]      = nack_nxt;
        stat_nxt[7:0]            = rdata_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            q           <= 2'd0;
            bit_idx     <= 4'd0;
            is_read     <= 1'b0;
            tx_byte     <= 8'd0;
            ack_lvl     <= 1'b0;
            rx_shift    <= 8'd0;
            ack_smp     <= 1'b0;
            rdata       <= 8'd0;
            nack        <= 1'b0;
            busy        <= 1'b0;
            scl_out     <= 1'b1;
            sda_out     <= 1'b1;
            sda_s1      <= 1'b1;
            sda_s2      <= 1'b1;
            relm.stat_q <= '0;
        end else begin
            state       <= state_nxt;
            q           <= q_nxt;
            bit_idx     <= bit_idx_nxt;
            is_read     <= is_read_nxt;
            tx_byte     <= tx_nxt;
            ack_lvl     <= ack_lvl_nxt;
            rx_shift    <= rx_nxt;
            ack_smp     <= ack_smp_nxt;
            rdata       <= rdata_nxt;
            nack        <= nack_nxt;
            busy        <= busy_nxt;
            scl_out     <= scl_nxt;
            sda_out     <= sda_nxt;
            sda_s1      <= sda_in;
            sda_s2      <= sda_s1;
            relm.stat_q <= stat_nxt;
        end
    end

endmodule

// File: tb/tb_relm_i2c_ctrl.sv
// Directed bench for relm_i2c_ctrl at DIV=4 with an open-drain slave model;
// the clock-stretch step is built only when I2C_STRETCH_EN is defined.
module tb_relm_i2c_ctrl;

    import relm_i2c_pkg::*;

    localparam int WD  = 32;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_in;
    logic scl_out, sda_out, sda_in;
    logic slave_sda;
`ifdef I2C_STRETCH_EN
    logic scl_in;
`endif

    int checks = 0;
    int errors = 0;

    relm_i2c_ctrl_if #(.WD(WD)) relm ();

    relm_i2c_ctrl #(.WD(WD), .DIV(DIV)) dut (
        .clk     (clk),
        .rst_in  (rst_in),
        .relm    (relm),
        .scl_out (scl_out),
        .sda_out (sda_out),
`ifdef I2C_STRETCH_EN
        .scl_in  (scl_in),
`endif
        .sda_in  (sda_in)
    );

    always #5 clk = ~clk;

    assign sda_in = sda_out & slave_sda;

    function automatic logic [WD:0] mk_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack);
        logic [WD:0] c;
        c              = '0;
        c[WD]          = 1'b1;
        c[CMD_OP +: 2] = op;
        c[7:0]         = data;
        c[CMD_ACK]     = ack;
        return c;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a command and holds it until the engine takes it (retry low before an edge).
    task automatic apply_stimulus(input logic [WD:0] cmd);
        logic r;
        int   guard;
        relm.cmd_d = cmd;
        guard      = 0;
        do begin
            r = relm.cmd_retry;
            @(posedge clk);
            #1;
            guard++;
        end while (r && guard < 2000);
        relm.cmd_d = '0;
        check_output("accept", r, 1'b0);
    endtask

    // Follows one transfer until busy falls; pat holds the slave's 9 SDA levels MSB first.
    task automatic watch(input logic [8:0] pat, input logic [WD:0] hold_cmd, input int stretch_at,
                         output int cycles, output logic [8:0] bits, output int sda_fall,
                         output logic [WD:0] busy_stat, output logic stall_seen);
        int   rises;
        int   stretch_left;
        logic p_scl, p_sda;
        relm.cmd_d   = hold_cmd;
        cycles       = 0;
        bits         = '0;
        rises        = 0;
        sda_fall     = -1;
        stall_seen   = 1'b0;
        stretch_left = 0;
        p_scl        = scl_out;
        p_sda        = sda_out;
        busy_stat    = relm.stat_q;
        slave_sda    = pat[8];
        while (relm.cmd_retry && cycles < 2000) begin
            busy_stat = relm.stat_q;
            @(posedge clk);
            #1;
            cycles++;
            if (stretch_left > 0) begin
                stretch_left--;
`ifdef I2C_STRETCH_EN
                if (stretch_left == 0) scl_in = 1'b1;
`endif
            end
            if (scl_out && !p_scl) begin
                bits = {bits[7:0], sda_out};
                rises++;
                if (rises == stretch_at) begin
                    stretch_left = 50;
`ifdef I2C_STRETCH_EN
                    scl_in = 1'b0;
`endif
                end
            end
            if (scl_out && p_scl && p_sda && !sda_out) sda_fall = cycles;
            if (!scl_out) slave_sda = (rises < 9) ? pat[8 - rises] : 1'b1;
            stall_seen = stall_seen | relm.stat_q[STAT_STALL];
            p_scl = scl_out;
            p_sda = sda_out;
        end
        slave_sda = 1'b1;
        check_output("busy_bounded", (cycles < 2000), 1'b1);
    endtask

    localparam logic [8:0] PAT_ACK  = 9'b1_1111_1110;
    localparam logic [8:0] PAT_NONE = 9'h1FF;

    initial begin
        int          cyc;
        int          fall;
        int          late_busy;
        logic [8:0]  bits;
        logic [WD:0] bstat;
        logic        stalled;

        rst_in     = 1'b1;
        slave_sda  = 1'b1;
        relm.cmd_d = '0;
`ifdef I2C_STRETCH_EN
        scl_in     = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        check_output("rst_scl", scl_out, 1'b1);
        check_output("rst_sda", sda_out, 1'b1);
        check_output("rst_stat", relm.stat_q, '0);
        check_output("rst_retry", relm.cmd_retry, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] START");
        apply_stimulus(mk_cmd(OP_START, 8'h00, 1'b0));
        watch(PAT_NONE, '0, 0, cyc, bits, fall, bstat, stalled);
        check_output("start_sda_fall", fall, 8);
        check_output("start_cycles", cyc, 4 * DIV);
        check_output("start_lines", {scl_out, sda_out}, 2'b00);

        $display("[TB] WRITE 0xA5 acked");
        apply_stimulus(mk_cmd(OP_WRITE, 8'hA5, 1'b0));
        watch(PAT_ACK, '0, 0, cyc, bits, fall, bstat, stalled);
        check_output("wr_a5_bits", bits, 9'h14B);
        check_output("wr_a5_cycles", cyc, 36 * DIV);
        check_output("wr_a5_stat", relm.stat_q, 33'h0_0000_0000);

        $display("[TB] WRITE 0x50 not acked");
        apply_stimulus(mk_cmd(OP_WRITE, 8'h50, 1'b0));
        watch(PAT_NONE, '0, 0, cyc, bits, fall, bstat, stalled);
        check_output("wr_50_bits", bits, 9'h0A1);
        check_output("wr_50_stat", relm.stat_q, 33'h0_0000_0100);

        $display("[TB] READ 0x3C with NACK");
        apply_stimulus(mk_cmd(OP_READ, 8'h00, 1'b1));
        watch({8'h3C, 1'b1}, '0, 0, cyc, bits, fall, bstat, stalled);
        check_output("rd_sda_released", bits, 9'h1FF);
        check_output("rd_cycles", cyc, 36 * DIV);
        check_output("rd_last_busy_stat", bstat, 33'h0_8000_0100);
        check_output("rd_stat", relm.stat_q, 33'h0_0000_013C);

        $display("[TB] command presented while busy");
        apply_stimulus(mk_cmd(OP_WRITE, 8'h12, 1'b0));
        check_output("busy_retry", relm.cmd_retry, 1'b1);
        watch(PAT_ACK, mk_cmd(OP_WRITE, 8'hFF, 1'b0), 0, cyc, bits, fall, bstat, stalled);
        check_output("busy_first_bits", bits, 9'h025);
        check_output("busy_first_cycles", cyc, 36 * DIV);
        check_output("busy_first_stall", stalled, 1'b0);
        check_output("busy_first_stat", relm.stat_q, 33'h0_0000_003C);
        apply_stimulus(mk_cmd(OP_WRITE, 8'hFF, 1'b0));
        watch(PAT_ACK, '0, 0, cyc, bits, fall, bstat, stalled);
        check_output("busy_second_bits", bits, 9'h1FF);
        check_output("busy_second_cycles", cyc, 36 * DIV);
        late_busy = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (relm.cmd_retry) late_busy++;
        end
        check_output("busy_runs_once", late_busy, 0);

        $display("[TB] STOP");
        apply_stimulus(mk_cmd(OP_STOP, 8'h00, 1'b0));
        watch(PAT_NONE, '0, 0, cyc, bits, fall, bstat, stalled);
        check_output("stop_cycles", cyc, 4 * DIV);
        check_output("stop_lines", {scl_out, sda_out}, 2'b11);
        check_output("stop_stat", relm.stat_q, 33'h0_0000_003C);

        $display("[TB] reset mid-transfer");
        apply_stimulus(mk_cmd(OP_WRITE, 8'h2A, 1'b0));
        repeat (12) @(posedge clk);
        #1;
        check_output("mid_lines_before", {scl_out, sda_out}, 2'b00);
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        check_output("mid_rst_lines", {scl_out, sda_out}, 2'b11);
        check_output("mid_rst_retry", relm.cmd_retry, 1'b0);
        check_output("mid_rst_stat", relm.stat_q, '0);
        @(posedge clk);
        #1;

`ifdef I2C_STRETCH_EN
        $display("[TB] clock stretch of 50 cycles");
        apply_stimulus(mk_cmd(OP_WRITE, 8'h00, 1'b0));
        watch(PAT_ACK, '0, 3, cyc, bits, fall, bstat, stalled);
        check_output("stretch_cycles", cyc, 36 * DIV + 50);
        check_output("stretch_stall_seen", stalled, 1'b1);
        check_output("stretch_bits", bits, 9'h001);
        check_output("stretch_stat", relm.stat_q, 33'h0_0000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
